// File: rtl/ifmap_feeder_pkg.sv
// Shared types and constants for the ifmap skew feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ifmap_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } feeder_state_e;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ROWS       = 4;

    // LSB position of lane 'lane' in a packed vector of 'width'-bit lanes
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/ifmap_skew_feeder_skew_line.sv
// Shift chain of {valid, data} registers delaying one lane by Depth cycles.
// Latency: Depth cycles from vld_i/dat_i to vld_o/dat_o.
// Backpressure: none; hold_i freezes every stage in place.
module skew_line #(
    parameter int Data_width = 8,
    parameter int Depth      = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  hold_i,
    input  logic                  vld_i,
    input  logic [Data_width-1:0] dat_i,
    output logic                  vld_o,
    output logic [Data_width-1:0] dat_o
);

    logic [Depth-1:0]                 vld_q, vld_d;
    logic [Depth-1:0][Data_width-1:0] dat_q, dat_d;

    // Next stage contents: shift by one unless held
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (!hold_i) begin
            vld_d[0] = vld_i;
            dat_d[0] = dat_i;
            for (int i = 1; i < Depth; i++) begin
                vld_d[i] = vld_q[i-1];
                dat_d[i] = dat_q[i-1];
            end
        end
    end

    // Chain registers, cleared on reset so in-flight data is discarded
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign vld_o = vld_q[Depth-1];
    assign dat_o = dat_q[Depth-1];

endmodule

// File: rtl/ifmap_skew_feeder.sv
// Feeds ifmap column vectors into the PE array left edge with row r delayed r cycles; optional stall via FEEDER_STALL_EN.
// Latency: vector accepted at edge t reaches row r in cycle t+1+r; tile_done in cycle t+Rows after the last vector.
// Backpressure: s_ready drops for Rows cycles while the last vector drains (and during iStall when enabled); no backpressure from the array.
module ifmap_skew_feeder
    import ifmap_feeder_pkg::*;
#(
    parameter int Data_width = DEF_DATA_WIDTH,
    parameter int Rows       = DEF_ROWS,
    parameter int Cnt_width  = $clog2(Rows) + 1
) (
    input  logic                       iClk,
    input  logic                       iRest_n,
`ifdef FEEDER_STALL_EN
    input  logic                       iStall,
`endif
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [Rows*Data_width-1:0] s_data,
    input  logic                       s_last,
    output logic [Rows*Data_width-1:0] Ifmap_t_array,
    output logic [Rows-1:0]            enable_in,
    output logic                       tile_done,
    output logic                       busy
);

    localparam logic [Cnt_width-1:0] CNT_LOAD = Cnt_width'(Rows - 1);

    feeder_state_e        state_q, state_d;
    logic [Cnt_width-1:0] cnt_q, cnt_d;
    logic                 stall;
    logic                 accept;

`ifdef FEEDER_STALL_EN
    assign stall = iStall;
`else
    assign stall = 1'b0;
`endif

    assign s_ready   = (state_q != DRAIN) && !stall;
    assign accept    = s_valid && s_ready;
    assign busy      = (state_q != IDLE);
    assign tile_done = (state_q == DRAIN) && (cnt_q == '0) && !stall;

    // One delay chain per row; bubbles carry zero data so the output is zero when not enabled
    for (genvar r = 0; r < Rows; r++) begin : g_lane
        logic [Data_width-1:0] lane_in;
        logic [Data_width-1:0] lane_out;
        logic                  lane_vld;

        assign lane_in = accept ? s_data[lane_lsb(r, Data_width) +: Data_width] : '0;

        skew_line #(
            .Data_width (Data_width),
            .Depth      (r + 1)
        ) u_skew_line (
            .clk_i  (iClk),
            .rst_ni (iRest_n),
            .hold_i (stall),
            .vld_i  (accept),
            .dat_i  (lane_in),
            .vld_o  (lane_vld),
            .dat_o  (lane_out)
        );

        assign enable_in[r] = lane_vld && !stall;
        assign Ifmap_t_array[lane_lsb(r, Data_width) +: Data_width] = stall ? '0 : lane_out;
    end

    // Tile tracking: stream until the last vector, then count it down through the deepest row
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!stall) begin
            case (state_q)
                IDLE, STREAM: begin
                    if (accept) begin
                        if (s_last) begin
                            state_d = DRAIN;
                            cnt_d   = CNT_LOAD;
                        end else begin
                            state_d = STREAM;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - Cnt_width'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and drain counter registers
    always_ff @(posedge iClk or negedge iRest_n) begin
        if (!iRest_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ifmap_skew_feeder.sv
// Self-checking bench for ifmap_skew_feeder (Rows=4, Data_width=8).
// Per-row scoreboard queues check beat order/value; per-cycle logs check timing.
// Stall scenario is compiled in only with FEEDER_STALL_EN.
module tb_ifmap_skew_feeder;

    localparam int DW   = 8;
    localparam int ROWS = 4;
    localparam int LOGN = 1024;

    logic                 iClk    = 1'b0;
    logic                 iRest_n = 1'b0;
    logic                 s_valid = 1'b0;
    logic                 s_last  = 1'b0;
    logic [ROWS*DW-1:0]   s_data  = '0;
    logic                 s_ready;
    logic [ROWS*DW-1:0]   Ifmap_t_array;
    logic [ROWS-1:0]      enable_in;
    logic                 tile_done;
    logic                 busy;
`ifdef FEEDER_STALL_EN
    logic                 iStall  = 1'b0;
`endif

    ifmap_skew_feeder #(
        .Data_width (DW),
        .Rows       (ROWS)
    ) dut (
        .iClk          (iClk),
        .iRest_n       (iRest_n),
`ifdef FEEDER_STALL_EN
        .iStall        (iStall),
`endif
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .s_last        (s_last),
        .Ifmap_t_array (Ifmap_t_array),
        .enable_in     (enable_in),
        .tile_done     (tile_done),
        .busy          (busy)
    );

    always #5 iClk = ~iClk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [7:0]         exp_q [ROWS][$];
    logic [ROWS-1:0]    log_en   [0:LOGN-1];
    logic [ROWS*DW-1:0] log_dat  [0:LOGN-1];
    logic               log_done [0:LOGN-1];
    logic               log_rdy  [0:LOGN-1];

    always @(posedge iClk) cyc <= cyc + 1;

    function automatic logic [7:0] lane_of(input logic [ROWS*DW-1:0] v, input int r);
        return v[r*DW +: DW];
    endfunction

    // Per-cycle log (index = cycle number after edge 'cyc') plus scoreboard pop on every enabled beat
    always @(negedge iClk) begin
        if (cyc + 1 < LOGN) begin
            log_en[cyc+1]   <= enable_in;
            log_dat[cyc+1]  <= Ifmap_t_array;
            log_done[cyc+1] <= tile_done;
            log_rdy[cyc+1]  <= s_ready;
        end
        if (iRest_n) begin
            for (int r = 0; r < ROWS; r++) begin
                tests = tests + 1;
                if (enable_in[r]) begin
                    if (exp_q[r].size() == 0) begin
                        fails = fails + 1;
                        $display("FAIL sb_row%0d: unexpected beat %h, none expected", r, lane_of(Ifmap_t_array, r));
                    end else begin
                        logic [7:0] e;
                        e = exp_q[r].pop_front();
                        if (lane_of(Ifmap_t_array, r) !== e) begin
                            fails = fails + 1;
                            $display("FAIL sb_row%0d: got %h, expected %h", r, lane_of(Ifmap_t_array, r), e);
                        end
                    end
                end else if (lane_of(Ifmap_t_array, r) !== 8'h00) begin
                    fails = fails + 1;
                    $display("FAIL idle_row%0d: data %h while disabled, expected 00", r, lane_of(Ifmap_t_array, r));
                end
            end
        end
    end

    // Offer one vector; returns the accepting edge index (or -1 on timeout)
    task automatic drive_vec(input logic [ROWS*DW-1:0] d, input logic last, output int t);
        bit ok;
        ok = 0;
        t  = -1;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge iClk);
            if (s_ready === 1'b1) ok = 1;
        end
        tests = tests + 1;
        if (!ok) begin
            fails = fails + 1;
            $display("FAIL accept_timeout: s_ready=%b after 20 cycles, expected 1", s_ready);
        end else begin
            for (int r = 0; r < ROWS; r++) exp_q[r].push_back(lane_of(d, r));
            @(posedge iClk);
            #1;
            t = cyc;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic test_reset();
        int t;
        int e;
        repeat (2) @(posedge iClk);
        #1;
        tests = tests + 1;
        if (enable_in !== '0 || Ifmap_t_array !== '0 || tile_done !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1) begin
            fails = fails + 1;
            $display("FAIL reset_state: en=%b dat=%h done=%b busy=%b rdy=%b, expected 0/0/0/0/1",
                     enable_in, Ifmap_t_array, tile_done, busy, s_ready);
        end
        iRest_n = 1'b1;
        drive_vec(32'hAABBCCDD, 1'b1, t);
        @(posedge iClk);
        #3;
        tests = tests + 1;
        if (busy !== 1'b1 || s_ready !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL drain_before_reset: busy=%b rdy=%b, expected 1/0", busy, s_ready);
        end
        iRest_n = 1'b0;
        #1;
        for (int r = 0; r < ROWS; r++) exp_q[r].delete();
        tests = tests + 1;
        if (enable_in !== '0 || Ifmap_t_array !== '0 || tile_done !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1) begin
            fails = fails + 1;
            $display("FAIL reset_mid_drain: en=%b dat=%h done=%b busy=%b rdy=%b, expected 0/0/0/0/1",
                     enable_in, Ifmap_t_array, tile_done, busy, s_ready);
        end
        @(posedge iClk);
        #1;
        iRest_n = 1'b1;
        e = cyc;
        repeat (7) @(posedge iClk);
        #1;
        for (int k = 1; k <= 6; k++) begin
            tests = tests + 1;
            if (log_done[e+k] !== 1'b0) begin
                fails = fails + 1;
                $display("FAIL no_done_after_reset: cycle +%0d tile_done=%b, expected 0", k, log_done[e+k]);
            end
        end
    endtask

    task automatic test_single();
        int t;
        drive_vec(32'h04030201, 1'b1, t);
        if (t < 0) return;
        repeat (6) @(posedge iClk);
        #1;
        for (int r = 0; r < ROWS; r++) begin
            tests = tests + 1;
            if (log_en[t+1+r][r] !== 1'b1 || lane_of(log_dat[t+1+r], r) !== 8'(r + 1)) begin
                fails = fails + 1;
                $display("FAIL single_row%0d: en=%b dat=%h, expected 1/%h", r, log_en[t+1+r][r],
                         lane_of(log_dat[t+1+r], r), 8'(r + 1));
            end
            tests = tests + 1;
            if (log_en[t+r][r] !== 1'b0 || log_en[t+2+r][r] !== 1'b0) begin
                fails = fails + 1;
                $display("FAIL single_pulse_row%0d: en before=%b after=%b, expected 0/0", r,
                         log_en[t+r][r], log_en[t+2+r][r]);
            end
        end
        for (int k = 1; k <= 5; k++) begin
            tests = tests + 1;
            if (log_rdy[k+t] !== (k == 5)) begin
                fails = fails + 1;
                $display("FAIL single_ready: cycle t+%0d s_ready=%b, expected %b", k, log_rdy[k+t], (k == 5));
            end
        end
        tests = tests + 1;
        if (log_done[t+3] !== 1'b0 || log_done[t+4] !== 1'b1 || log_done[t+5] !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL single_done: t+3..t+5 = %b%b%b, expected 010", log_done[t+3], log_done[t+4], log_done[t+5]);
        end
    endtask

    task automatic test_stream();
        int t0, t1, t2;
        drive_vec(32'h14131211, 1'b0, t0);
        drive_vec(32'h24232221, 1'b0, t1);
        drive_vec(32'h34333231, 1'b1, t2);
        if (t0 < 0 || t2 < 0) return;
        tests = tests + 1;
        if (t1 !== t0 + 1 || t2 !== t0 + 2) begin
            fails = fails + 1;
            $display("FAIL stream_accept: edges %0d,%0d,%0d, expected consecutive", t0, t1, t2);
        end
        repeat (8) @(posedge iClk);
        #1;
        for (int r = 0; r < ROWS; r++) begin
            for (int k = 0; k < 3; k++) begin
                tests = tests + 1;
                if (log_en[t0+1+r+k][r] !== 1'b1 || lane_of(log_dat[t0+1+r+k], r) !== 8'((k + 1) * 16 + 1 + r)) begin
                    fails = fails + 1;
                    $display("FAIL stream_row%0d_beat%0d: en=%b dat=%h, expected 1/%h", r, k,
                             log_en[t0+1+r+k][r], lane_of(log_dat[t0+1+r+k], r), 8'((k + 1) * 16 + 1 + r));
                end
            end
        end
        tests = tests + 1;
        if (log_done[t0+5] !== 1'b0 || log_done[t0+6] !== 1'b1 || lane_of(log_dat[t0+6], 3) !== 8'h34) begin
            fails = fails + 1;
            $display("FAIL stream_done: done t+5/t+6=%b%b row3=%h, expected 01/34",
                     log_done[t0+5], log_done[t0+6], lane_of(log_dat[t0+6], 3));
        end
    endtask

    task automatic test_bubble();
        int t0, t1;
        drive_vec(32'h44434241, 1'b0, t0);
        @(posedge iClk);
        #1;
        drive_vec(32'h54535251, 1'b1, t1);
        if (t0 < 0 || t1 < 0) return;
        tests = tests + 1;
        if (t1 !== t0 + 2) begin
            fails = fails + 1;
            $display("FAIL bubble_accept: second edge %0d, expected %0d", t1, t0 + 2);
        end
        repeat (7) @(posedge iClk);
        #1;
        for (int r = 0; r < ROWS; r++) begin
            tests = tests + 1;
            if (log_en[t0+1+r][r] !== 1'b1 || lane_of(log_dat[t0+1+r], r) !== 8'(8'h41 + r) ||
                log_en[t0+2+r][r] !== 1'b0 || lane_of(log_dat[t0+2+r], r) !== 8'h00 ||
                log_en[t0+3+r][r] !== 1'b1 || lane_of(log_dat[t0+3+r], r) !== 8'(8'h51 + r)) begin
                fails = fails + 1;
                $display("FAIL bubble_row%0d: en=%b%b%b dat=%h,%h,%h, expected 101 %h,00,%h", r,
                         log_en[t0+1+r][r], log_en[t0+2+r][r], log_en[t0+3+r][r],
                         lane_of(log_dat[t0+1+r], r), lane_of(log_dat[t0+2+r], r), lane_of(log_dat[t0+3+r], r),
                         8'(8'h41 + r), 8'(8'h51 + r));
            end
        end
        tests = tests + 1;
        if (log_done[t1+4] !== 1'b1) begin
            fails = fails + 1;
            $display("FAIL bubble_done: tile_done=%b at t+4, expected 1", log_done[t1+4]);
        end
    endtask

    task automatic test_back_to_back();
        int ta0, ta, tb;
        drive_vec(32'h64636261, 1'b0, ta0);
        drive_vec(32'h74737271, 1'b1, ta);
        drive_vec(32'h84838281, 1'b1, tb);
        if (ta < 0 || tb < 0) return;
        tests = tests + 1;
        if (tb !== ta + 5) begin
            fails = fails + 1;
            $display("FAIL b2b_next_accept: edge %0d, expected %0d", tb, ta + 5);
        end
        repeat (7) @(posedge iClk);
        #1;
        for (int k = 1; k <= 4; k++) begin
            tests = tests + 1;
            if (log_rdy[ta+k] !== 1'b0) begin
                fails = fails + 1;
                $display("FAIL b2b_ready_gap: t+%0d s_ready=%b, expected 0", k, log_rdy[ta+k]);
            end
        end
        tests = tests + 1;
        if (log_done[ta+4] !== 1'b1 || log_rdy[ta+5] !== 1'b1) begin
            fails = fails + 1;
            $display("FAIL b2b_boundary: done t+4=%b rdy t+5=%b, expected 1/1", log_done[ta+4], log_rdy[ta+5]);
        end
        tests = tests + 1;
        if (log_done[tb+4] !== 1'b1 || lane_of(log_dat[tb+4], 3) !== 8'h84) begin
            fails = fails + 1;
            $display("FAIL b2b_second_done: done=%b row3=%h, expected 1/84", log_done[tb+4], lane_of(log_dat[tb+4], 3));
        end
    endtask

`ifdef FEEDER_STALL_EN
    task automatic test_stall();
        int t0, t1;
        drive_vec(32'h94939291, 1'b0, t0);
        iStall = 1'b1;
        repeat (2) @(posedge iClk);
        #1;
        iStall = 1'b0;
        drive_vec(32'hA4A3A2A1, 1'b1, t1);
        if (t0 < 0 || t1 < 0) return;
        tests = tests + 1;
        if (t1 !== t0 + 3) begin
            fails = fails + 1;
            $display("FAIL stall_accept: edge %0d, expected %0d", t1, t0 + 3);
        end
        repeat (8) @(posedge iClk);
        #1;
        for (int k = 1; k <= 2; k++) begin
            tests = tests + 1;
            if (log_rdy[t0+k] !== 1'b0 || log_en[t0+k] !== '0 || log_dat[t0+k] !== '0 || log_done[t0+k] !== 1'b0) begin
                fails = fails + 1;
                $display("FAIL stall_outputs: t+%0d rdy=%b en=%b dat=%h done=%b, expected all 0", k,
                         log_rdy[t0+k], log_en[t0+k], log_dat[t0+k], log_done[t0+k]);
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            tests = tests + 1;
            if (log_en[t0+3+r][r] !== 1'b1 || lane_of(log_dat[t0+3+r], r) !== 8'(8'h91 + r) ||
                log_en[t0+4+r][r] !== 1'b1 || lane_of(log_dat[t0+4+r], r) !== 8'(8'hA1 + r)) begin
                fails = fails + 1;
                $display("FAIL stall_resume_row%0d: en=%b%b dat=%h,%h, expected 11 %h,%h", r,
                         log_en[t0+3+r][r], log_en[t0+4+r][r], lane_of(log_dat[t0+3+r], r),
                         lane_of(log_dat[t0+4+r], r), 8'(8'h91 + r), 8'(8'hA1 + r));
            end
        end
        tests = tests + 1;
        if (log_done[t0+6] !== 1'b0 || log_done[t0+7] !== 1'b1) begin
            fails = fails + 1;
            $display("FAIL stall_done: done t+6/t+7=%b%b, expected 01", log_done[t0+6], log_done[t0+7]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_bubble();
        test_back_to_back();
`ifdef FEEDER_STALL_EN
        test_stall();
`endif
        repeat (3) @(posedge iClk);
        #1;
        for (int r = 0; r < ROWS; r++) begin
            tests = tests + 1;
            if (exp_q[r].size() != 0) begin
                fails = fails + 1;
                $display("FAIL sb_drain_row%0d: %0d beats never delivered, expected 0", r, exp_q[r].size());
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
